// File: rtl/data_mem_responder.sv
// Purpose : responder for the CPU data-memory port; serves one load/store at a time from a word RAM.
// Latency : ack pulses WAIT+1 cycles after the accept edge; one transaction per WAIT+2 cycles at best.
// Backpr. : o_ready is low from accept until the cycle after ack; a request seen while not ready is ignored.
//
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_req/i_we/i_addr/i_wdata/i_be : request, sampled on the accept edge
//   o_ready                        : may accept this cycle
//   o_ack/o_rdata/o_err            : one-cycle completion with load data / error status
module data_mem_responder #(
    parameter int ADDR_W = 6,
    parameter int WAIT   = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_be,
    output logic        o_ready,
    output logic        o_ack,
    output logic [31:0] o_rdata,
    output logic        o_err
);
    localparam int         DEPTH       = 1 << ADDR_W;
    localparam logic [2:0] LP_CNT_INIT = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             r_state;
    logic [2:0]         r_cnt;
    logic               r_ready;
    logic               r_ack;
    logic               r_err;
    logic [31:0]        r_rdata;
    logic               r_we;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_be;
    logic [31:0]        r_mem [DEPTH];

    logic               w_accept;
    logic               w_to_resp;
    logic               w_we;
    logic [31:0]        w_addr;
    logic [31:0]        w_wdata;
    logic [3:0]         w_be;
    logic               w_err;
    logic [ADDR_W-1:0]  w_idx;
    logic               w_commit;

    assign w_accept  = (r_state == S_IDLE) && r_ready && i_req;
    assign w_to_resp = (w_accept && (WAIT == 0)) || ((r_state == S_WAIT) && (r_cnt == 3'd0));

    // With no wait states RESP is entered on the accept edge itself, before the
    // latched copy exists, so the live request fields are used on that edge.
    assign w_we    = w_accept ? i_we    : r_we;
    assign w_addr  = w_accept ? i_addr  : r_addr;
    assign w_wdata = w_accept ? i_wdata : r_wdata;
    assign w_be    = w_accept ? i_be    : r_be;

    assign w_err    = (w_addr[1:0] != 2'b00) || ((w_addr >> (ADDR_W + 2)) != 32'd0);
    assign w_idx    = w_addr[ADDR_W+1:2];
    assign w_commit = w_to_resp && w_we && !w_err;

    // RAM has no reset; a reset before the commit edge keeps w_commit low
    // because the FSM is forced back to IDLE with ready low.
    always_ff @(posedge i_clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_ready <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_we    <= i_we;
                        r_addr  <= i_addr;
                        r_wdata <= i_wdata;
                        r_be    <= i_be;
                        r_ready <= 1'b0;
                        if (WAIT == 0) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= LP_CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Response fields only move on the edge entering RESP and hold otherwise.
            if (w_to_resp) begin
                r_ack   <= 1'b1;
                r_err   <= w_err;
                r_rdata <= (w_err || w_we) ? 32'd0 : r_mem[w_idx];
            end
        end
    end

    assign o_ready = r_ready;
    assign o_ack   = r_ack;
    assign o_rdata = r_rdata;
    assign o_err   = r_err;

endmodule
